// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined processor datapath.
// Holds the datapath/control widths, the control-word bit positions used by
// the memory-access stage, and the packed bundle held in the MA/RW register.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 22;

    // Bit positions inside the control word produced by EX
    localparam int CTRL_IS_LD = 0;
    localparam int CTRL_IS_ST = 1;

    // Contents of the MA/RW pipeline register
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] alu_res;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] ld_data;
    } ma_rw_t;

endpackage : pipe_pkg

// File: rtl/data_mem.sv
// Single-port word RAM for the memory-access stage.
// Write is synchronous on the rising clock edge; read is combinational so the
// load result can be captured into the MA/RW register on the same edge.
// Contents are never reset.
// Ports:
//   clk   in   rising-edge clock
//   we    in   write enable (full word)
//   addr  in   word index
//   wdata in   write data
//   rdata out  combinational read data at addr (value before any write this edge)
module data_mem
    import pipe_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [MEM_WORDS];

    // Word write; the array is deliberately left out of any reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
    end

    assign rdata = mem_r[addr];

endmodule : data_mem

// File: rtl/ma_stage.sv
// Memory-access (MA) stage, sitting between EX and write-back (RW).
// Performs the load or store selected by the EX control word against the
// word-addressed data memory and registers pc, instruction, ALU result,
// control word and load data into the MA/RW pipeline register.
// DATA_W and CTRL_W must match the pipe_pkg values, since the register
// bundle type is defined there.
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous reset, active low
//   pc_MA_in            in   PC of the instruction in MA
//   aluResult           in   effective byte address / ALU result
//   op2                 in   store data
//   inst_out_ex         in   instruction word from EX
//   control_signals_ex  in   control word from EX (bit0 isLd, bit1 isSt)
//   pc_MA_out           out  registered pc_MA_in
//   ldResult            out  registered load data (0 when not loading)
//   inst_out_ma         out  registered inst_out_ex
//   alu_res_MA          out  registered aluResult
//   control_MA          out  registered control_signals_ex
module ma_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = pipe_pkg::DATA_W,
    parameter int CTRL_W    = pipe_pkg::CTRL_W,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_MA_in,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] inst_out_ex,
    input  logic [CTRL_W-1:0] control_signals_ex,
    output logic [DATA_W-1:0] pc_MA_out,
    output logic [DATA_W-1:0] ldResult,
    output logic [DATA_W-1:0] inst_out_ma,
    output logic [DATA_W-1:0] alu_res_MA,
    output logic [CTRL_W-1:0] control_MA
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [AW-1:0]     word_idx_s;
    logic              is_ld_s;
    logic              is_st_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] rd_data_s;
    ma_rw_t            ma_rw_next_s;
    ma_rw_t            ma_rw_r;

    // Byte offset and bits above the index are dropped, so addresses wrap
    assign word_idx_s = aluResult[AW+1:2];
    assign is_ld_s    = control_signals_ex[CTRL_IS_LD];
    assign is_st_s    = control_signals_ex[CTRL_IS_ST];
    // A store presented while reset is held is discarded
    assign mem_we_s   = is_st_s & rst;

    data_mem #(
        .WORD_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (word_idx_s),
        .wdata (op2),
        .rdata (rd_data_s)
    );

    // Next MA/RW contents; rd_data_s is the pre-write word, giving
    // read-before-write when load and store coincide
    always_comb begin
        ma_rw_next_s         = '0;
        ma_rw_next_s.pc      = pc_MA_in;
        ma_rw_next_s.inst    = inst_out_ex;
        ma_rw_next_s.alu_res = aluResult;
        ma_rw_next_s.ctrl    = control_signals_ex;
        if (is_ld_s) begin
            ma_rw_next_s.ld_data = rd_data_s;
        end else begin
            ma_rw_next_s.ld_data = '0;
        end
    end

    // MA/RW pipeline register, advances every edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_rw_r <= '0;
        end else begin
            ma_rw_r <= ma_rw_next_s;
        end
    end

    assign pc_MA_out   = ma_rw_r.pc;
    assign inst_out_ma = ma_rw_r.inst;
    assign alu_res_MA  = ma_rw_r.alu_res;
    assign control_MA  = ma_rw_r.ctrl;
    assign ldResult    = ma_rw_r.ld_data;

endmodule : ma_stage

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: directed cases plus randomized traffic
// compared against a word-array reference model of the data memory.
module tb_ma_stage;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] pc_MA_in;
    logic [31:0] aluResult;
    logic [31:0] op2;
    logic [31:0] inst_out_ex;
    logic [21:0] control_signals_ex;
    logic [31:0] pc_MA_out;
    logic [31:0] ldResult;
    logic [31:0] inst_out_ma;
    logic [31:0] alu_res_MA;
    logic [21:0] control_MA;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mdl_mem [MEM_WORDS];

    ma_stage #(
        .DATA_W    (32),
        .CTRL_W    (22),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_MA_in           (pc_MA_in),
        .aluResult          (aluResult),
        .op2                (op2),
        .inst_out_ex        (inst_out_ex),
        .control_signals_ex (control_signals_ex),
        .pc_MA_out          (pc_MA_out),
        .ldResult           (ldResult),
        .inst_out_ma        (inst_out_ma),
        .alu_res_MA         (alu_res_MA),
        .control_MA         (control_MA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_pc"},   pc_MA_out,          32'h0);
        check_val({tag, "_ld"},   ldResult,           32'h0);
        check_val({tag, "_inst"}, inst_out_ma,        32'h0);
        check_val({tag, "_alu"},  alu_res_MA,         32'h0);
        check_val({tag, "_ctrl"}, {10'h0, control_MA}, 32'h0);
    endtask

    // Present one instruction, advance one edge, and compare all outputs
    // with the reference model (reset must be released)
    task automatic apply(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [21:0] ctrl, input logic do_check);
        int          idx;
        logic [31:0] exp_ld;
        pc_MA_in           = pc;
        inst_out_ex        = inst;
        aluResult          = addr;
        op2                = data;
        control_signals_ex = ctrl;
        idx    = int'((addr >> 2) % MEM_WORDS);
        exp_ld = ctrl[0] ? mdl_mem[idx] : 32'h0;
        if (ctrl[1]) mdl_mem[idx] = data;
        @(posedge clk);
        #1;
        if (do_check) begin
            check_val({tag, "_pc"},   pc_MA_out,            pc);
            check_val({tag, "_inst"}, inst_out_ma,          inst);
            check_val({tag, "_alu"},  alu_res_MA,           addr);
            check_val({tag, "_ctrl"}, {10'h0, control_MA},  {10'h0, ctrl});
            check_val({tag, "_ld"},   ldResult,             exp_ld);
        end
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [21:0] r_ctrl;
        logic [31:0] idx_set [8];

        for (int i = 0; i < MEM_WORDS; i++) mdl_mem[i] = 32'h0;

        // Reset with non-zero inputs
        rst                = 1'b0;
        pc_MA_in           = 32'hDEADBEEF;
        aluResult          = 32'h00000044;
        op2                = 32'hCAFEF00D;
        inst_out_ex        = 32'h0BADC0DE;
        control_signals_ex = 22'h3FFFFF;
        #2;
        check_all_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Bring memory to a known all-zero state
        for (int i = 0; i < MEM_WORDS; i++)
            apply("init", 32'h0, 32'h0, i * 4, 32'h0, 22'h000002, 1'b0);

        // Store then load
        apply("st10",  32'h00000000, 32'h00000000, 32'h10, 32'hA5A5A5A5, 22'h000002, 1'b1);
        apply("ld10",  32'h00000004, 32'h00000000, 32'h10, 32'h00000000, 22'h000001, 1'b1);
        // Pass-through
        apply("pass",  32'h00000040, 32'h12345678, 32'h0,  32'h0,        22'h2AAAA5, 1'b1);
        // Load disabled
        apply("nold",  32'h00000044, 32'h0,        32'h10, 32'h0,        22'h000000, 1'b1);
        // Simultaneous load and store
        apply("st20",  32'h48, 32'h0, 32'h20, 32'h11111111, 22'h000002, 1'b1);
        apply("ldst",  32'h4C, 32'h0, 32'h20, 32'h22222222, 22'h000003, 1'b1);
        apply("ld20",  32'h50, 32'h0, 32'h20, 32'h0,        22'h000001, 1'b1);
        // Wrap modulo MEM_WORDS*4, byte offset ignored
        apply("stwrap", 32'h54, 32'h0, 32'h10 + MEM_WORDS * 4, 32'h5A5A1234, 22'h000002, 1'b1);
        apply("ldwrap", 32'h58, 32'h0, 32'h13,                 32'h0,        22'h000001, 1'b1);

        // Reset mid-operation with a pending store that must be dropped
        @(negedge clk);
        pc_MA_in           = 32'h60;
        aluResult          = 32'h10;
        op2                = 32'hFFFF0000;
        control_signals_ex = 22'h000002;
        rst                = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_mid_edge");
        @(negedge clk);
        rst = 1'b1;
        #1;
        apply("ldret", 32'h64, 32'h0, 32'h10, 32'h0, 22'h000001, 1'b1);

        // Randomized traffic over a small address set, random upper bits
        for (int i = 0; i < 8; i++) idx_set[i] = 32'(i * 4 + 64);
        for (int i = 0; i < 300; i++) begin
            r_addr = idx_set[$urandom_range(7, 0)] + (32'($urandom_range(3, 0)) << 12)
                     + 32'($urandom_range(3, 0));
            r_ctrl = 22'($urandom);
            apply("rnd", $urandom, $urandom, r_addr, $urandom, r_ctrl, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_ma_stage
